// File: rtl/data_memory_block.sv
// -----------------------------------------------------------------------------
// data_memory_block
//   Block-granular main data memory sitting directly behind the data cache.
//   Each access takes a fixed ACCESS_CYCLES edges once latched. The cache is
//   stalled through a combinational busywait, so the stall is visible in the
//   same cycle the request first appears.
//
// Ports
//   clk            in   system clock, all state updates on posedge
//   reset          in   synchronous, active-high reset (clears the whole array)
//   mem_read       in   block read request, held until busywait drops
//   mem_write      in   block write request, held until busywait drops
//                       (write wins if both are high)
//   mem_address    in   block address {tag, index}
//   mem_writedata  in   block to write
//   mem_readdata   out  registered read block, changes only on read or reset
//   mem_busywait   out  combinational stall to the cache
// -----------------------------------------------------------------------------
module data_memory_block #(
   parameter int ADDR_WIDTH    = 6,
   parameter int DATA_WIDTH    = 32,
   parameter int ACCESS_CYCLES = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [DATA_WIDTH-1:0] mem_writedata,
   output logic [DATA_WIDTH-1:0] mem_readdata,
   output logic                  mem_busywait
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // Counter only has to hold ACCESS_CYCLES-1.
   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

   if (ACCESS_CYCLES < 1) begin : g_cfg_check
      $error("data_memory_block: ACCESS_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [CNT_W-1:0]      r_count;
   logic                  r_op_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] r_readdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic                  w_req;
   logic                  w_busywait;

   assign w_req        = mem_read | mem_write;
   assign mem_busywait = w_busywait;
   assign mem_readdata = r_readdata;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples pre-edge values regardless of process ordering.
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and stall decode.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output
      // unassigned, which would infer a latch.
      w_next_state = r_state;
      w_busywait   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Stall in the very cycle a request shows up, before it is latched.
            if (w_req) begin
               w_busywait   = 1'b1;
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_busywait = 1'b1;
            if (r_count == '0) w_next_state = S_DONE;
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Request latch, latency counter, array and read register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count    <= '0;
         r_op_write <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_readdata <= '0;
         // NOTE: the array is cleared by reset, so it is built from flops rather
         // than a RAM macro; an in-flight write is dropped by this branch too.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_op_write <= mem_write;
                  r_addr     <= mem_address;
                  r_data     <= mem_writedata;
                  r_count    <= CNT_INIT;
               end
            end
            S_ACCESS: begin
               // Inputs are ignored here; the latched op always completes.
               if (r_count != '0)   r_count        <= r_count - 1'b1;
               else if (r_op_write) r_mem[r_addr]  <= r_data;
               else                 r_readdata     <= r_mem[r_addr];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_block.sv
// -----------------------------------------------------------------------------
// tb_data_memory_block
//   Self-checking bench for data_memory_block. Two instances: the default
//   ACCESS_CYCLES=5 build and an ACCESS_CYCLES=1 build. A plain array model per
//   instance holds the expected contents and the last value read.
// -----------------------------------------------------------------------------
module tb_data_memory_block;

   localparam int AW = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;

   // Instance 0: ACCESS_CYCLES = 5
   logic          mem_read, mem_write, mem_busywait;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_writedata, mem_readdata;

   // Instance 1: ACCESS_CYCLES = 1
   logic          rd1, wr1, busy1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1, rdata1;

   int            n_checks = 0;
   int            n_errors = 0;

   logic [DW-1:0] ref_mem   [2][64];
   logic [DW-1:0] ref_rdata [2];
   int            ref_cycles [2] = '{5, 1};

   always #5 clk = ~clk;

   data_memory_block #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(5)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   data_memory_block #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1)) u_dut1 (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (rd1),
      .mem_write    (wr1),
      .mem_address  (addr1),
      .mem_writedata(wdata1),
      .mem_readdata (rdata1),
      .mem_busywait (busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 64; i++) ref_mem[s][i] = '0;
         ref_rdata[s] = '0;
      end
   endtask

   task automatic drive(input bit sel, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (sel) begin
         rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
      end else begin
         mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
      end
   endtask

   function automatic logic busy_of(input bit sel);
      return sel ? busy1 : mem_busywait;
   endfunction

   // One cache-style access. Entered just after a posedge; returns just after
   // the DONE->IDLE posedge with the request already dropped.
   task automatic access(input string tag, input bit sel, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      int busy_cycles;
      bit done;
      busy_cycles = 0;
      done        = 1'b0;
      drive(sel, rd, wr, a, d);
      if (wr) ref_mem[sel][a] = d;
      else    ref_rdata[sel]  = ref_mem[sel][a];
      @(negedge clk);
      check({tag, " busy_in_req_cycle"}, 32'(busy_of(sel)), 32'd1);
      busy_cycles = 1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (busy_of(sel)) busy_cycles++;
         else              done = 1'b1;
      end
      check({tag, " completed"}, 32'(done), 32'd1);
      check({tag, " busy_cycles"}, busy_cycles, ref_cycles[sel] + 1);
      check({tag, " readdata"}, sel ? rdata1 : mem_readdata, ref_rdata[sel]);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      bit done;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      ref_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("reset busywait", 32'(mem_busywait), 32'd0);
      check("reset readdata", mem_readdata, 32'd0);
      @(posedge clk);
      #1;

      access("rd_2a", 1'b0, 1'b1, 1'b0, 6'h2A, 32'h0);
      access("wr_15", 1'b0, 1'b0, 1'b1, 6'h15, 32'hDEADBEEF);
      access("rd_15", 1'b0, 1'b1, 1'b0, 6'h15, 32'h0);

      // Write-back then immediate fetch; the fetch's first-cycle busy check
      // confirms the low window between them is a single cycle.
      access("wr_27", 1'b0, 1'b0, 1'b1, 6'h27, 32'hCAFEF00D);
      access("wb_07", 1'b0, 1'b0, 1'b1, 6'h07, 32'h11223344);
      access("fetch_27", 1'b0, 1'b1, 1'b0, 6'h27, 32'h0);
      access("rd_07", 1'b0, 1'b1, 1'b0, 6'h07, 32'h0);

      access("both_3f", 1'b0, 1'b1, 1'b1, 6'h3F, 32'hA5A5A5A5);
      access("rd_3f", 1'b0, 1'b1, 1'b0, 6'h3F, 32'h0);

      // Request dropped and address moved mid-access.
      access("wr_11", 1'b0, 1'b0, 1'b1, 6'h11, 32'h0BADF00D);
      drive(1'b0, 1'b0, 1'b1, 6'h10, 32'h12345678);
      ref_mem[0][6'h10] = 32'h12345678;
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 6'h11, 32'hFFFFFFFF);
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (!mem_busywait) done = 1'b1;
      end
      check("drop completed", 32'(done), 32'd1);
      @(posedge clk); #1;
      access("rd_10", 1'b0, 1'b1, 1'b0, 6'h10, 32'h0);
      access("rd_11", 1'b0, 1'b1, 1'b0, 6'h11, 32'h0);

      // Reset in the middle of a write.
      drive(1'b0, 1'b0, 1'b1, 6'h01, 32'h55AA55AA);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 6'h01, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      ref_reset();
      @(negedge clk);
      check("midreset busywait", 32'(mem_busywait), 32'd0);
      check("midreset readdata", mem_readdata, 32'd0);
      @(posedge clk); #1;
      access("rd_01", 1'b0, 1'b1, 1'b0, 6'h01, 32'h0);

      // Randomized traffic with idle gaps.
      for (int n = 0; n < 60; n++) begin
         int op, gap;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         op  = $urandom_range(0, 3);
         gap = $urandom_range(0, 2);
         a   = AW'($urandom_range(0, 15));
         d   = $urandom;
         access($sformatf("rnd%0d", n), 1'b0, (op == 0 || op == 2 || op == 3),
                (op == 1 || op == 2), a, d);
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end

      // Single-cycle latency build.
      access("ac1 wr_05", 1'b1, 1'b0, 1'b1, 6'h05, 32'h13579BDF);
      access("ac1 rd_05", 1'b1, 1'b1, 1'b0, 6'h05, 32'h0);
      access("ac1 rd_06", 1'b1, 1'b1, 1'b0, 6'h06, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
